alu_seq: RTL

- Parametrised, multi-cycle successor to the combinational VeriRISC ALU.
- Keeps the opcode map (add, sub, mul, div) and zero flag, and adds:
  - remainder and logic ops;
  - overflow and divide-by-zero flags;
  - iterative shift-add multiply and restoring divide, taking WIDTH cycles each;
  - valid/ready handshakes on both input and output.
- Sits between the VeriRISC decode stage and writeback; the core stalls on ready_out/valid_out.

---
 rtl/alu_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle VeriRISC ALU with shift-add multiply, restoring divide and valid/ready handshakes.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] y_out,
    output logic             z_out,
    output logic             ovf_out,
    output logic             dz_out
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_AND = 3'd3,
                           OP_DIV = 3'd4, OP_REM = 3'd5, OP_OR  = 3'd6, OP_XOR = 3'd7;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, y_q;
    logic [2:0]           op_q;
    logic                 z_q, ovf_q, dz_q;
    logic [WIDTH:0]       add_s, sub_s, mul_sum, div_sh;
    logic [WIDTH-1:0]     div_rem, fast_y, calc_y;
    logic                 div_ge, is_divop, is_long, fast_ovf, fast_dz, calc_ovf;
    // acc_q holds {high/remainder, low/quotient}; MUL and DIV both start from {0, a}
    always_comb begin
        add_s    = {1'b0, a_in} + {1'b0, b_in};
        sub_s    = {1'b0, a_in} - {1'b0, b_in};
        is_divop = (op_in == OP_DIV) || (op_in == OP_REM);
        is_long  = (op_in == OP_MUL) || (is_divop && b_in != '0);
        fast_dz  = is_divop && b_in == '0;
        fast_ovf = (op_in == OP_ADD) ? add_s[WIDTH] : (op_in == OP_SUB) ? sub_s[WIDTH] : 1'b0;
        fast_y   = (op_in == OP_ADD) ? add_s[WIDTH-1:0] :
                   (op_in == OP_SUB) ? sub_s[WIDTH-1:0] :
                   (op_in == OP_AND) ? (a_in & b_in) :
                   (op_in == OP_OR)  ? (a_in | b_in) :
                   (op_in == OP_XOR) ? (a_in ^ b_in) : '0;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, b_q};
        div_rem  = div_ge ? (div_sh[WIDTH-1:0] - b_q) : div_sh[WIDTH-1:0];
        acc_d    = (op_q == OP_MUL) ?
                   (acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]}) :
                   {div_rem, acc_q[WIDTH-2:0], div_ge};
        calc_y   = (op_q == OP_REM) ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
        calc_ovf = (op_q == OP_MUL) && (acc_d[2*WIDTH-1:WIDTH] != '0);
    end
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            y_q     <= '0;
            z_q     <= 1'b0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (valid_in) begin
                    op_q  <= op_in;
                    b_q   <= b_in;
                    acc_q <= {{WIDTH{1'b0}}, a_in};
                    if (is_long) begin
                        state_q <= CALC;
                        cnt_q   <= CNT_W'(WIDTH - 1);
                    end else begin
                        state_q <= DONE;
                        y_q     <= fast_y;
                        z_q     <= fast_y == '0;
                        ovf_q   <= fast_ovf;
                        dz_q    <= fast_dz;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        y_q     <= calc_y;
                        z_q     <= calc_y == '0;
                        ovf_q   <= calc_ovf;
                        dz_q    <= 1'b0;
                    end
                end
                DONE: if (ready_in) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ready_out = state_q == IDLE;
    assign valid_out = state_q == DONE;
    assign y_out     = y_q;
    assign z_out     = z_q;
    assign ovf_out   = ovf_q;
    assign dz_out    = dz_q;
endmodule
